muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit in the EX stage of the 5-stage MIPS core. It consumes the 5-bit `alucontrol` code and the two EX operands. For MULT/MULTU/DIV/DIVU it computes a 64-bit {hi, lo} result over multiple cycles, stalling the pipeline until the result is ready. The result feeds the HI/LO write path in the same way as the single-cycle ALU result.

## Interface
Parameters:
- `DIV_ITER`, 32: number of radix-2 divide iterations; fixed at the operand width.

Ports:
- `clk`  in  1  core clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `alucontrol`  in  5  EX-stage ALU control; encodings per defines2.vh `MULT_CONTROL`, `MULTU_CONTROL`, `DIV_CONTROL`, `DIVU_CONTROL`; any other value is not an operation for this block
- `valid_e`  in  1  EX stage holds a live instruction
- `flush_i`  in  1  EX flush (exception or eret); aborts any operation
- `hold_i`  in  1  downstream stall; freezes DONE state
- `a`  in  32  rs operand (dividend / multiplicand)
- `b`  in  32  rt operand (divisor / multiplier)
- `stall_o`  out  1  request pipeline stall from F to E
- `result_valid_o`  out  1  hi_o/lo_o hold the result of the current EX instruction
- `hi_o`  out  32  HI result (product[63:32] or remainder)
- `lo_o`  out  32  LO result (product[31:0] or quotient)

## Operation
- `start` = `valid_e & ~flush_i & (alucontrol ∈ {MULT, MULTU, DIV, DIVU})`.
- `signed_op` is 1 for MULT and DIV.
- States: IDLE, MUL, DIV, DONE. Reset state is IDLE.
- IDLE:
  - on `start`, latch `a`, `b`, `signed_op` and op type.
  - MUL/MULTU → MUL.
  - DIV/DIVU with `b`≠0 → DIV, with a 6-bit iteration counter cleared.
  - DIV/DIVU with `b`=0 → DONE, with `hi_o`=`a` and `lo_o`=32'hFFFFFFFF.
- MUL:
  - form the full 64-bit product; signed if `signed_op`, else unsigned.
  - register it to {hi_o, lo_o}; → DONE.
- DIV:
  - entry step: operands are converted to magnitudes when `signed_op`.
  - iteration step: one restoring shift-subtract iteration per cycle on a 33-bit partial remainder.
  - after iteration 32 (counter = 31 on that cycle), apply sign correction and load outputs; → DONE.
  - quotient is negated iff `signed_op` and sign(a)≠sign(b).
  - remainder is negated iff `signed_op` and a<0.
  - 0x80000000 / 0xFFFFFFFF signed → lo=0x80000000, hi=0; no trap.
- DONE:
  - `result_valid_o`=1.
  - stays in DONE while `hold_i`=1; otherwise → IDLE.
  - `start` is never sampled in DONE, so the retiring instruction cannot retrigger.
- `flush_i`=1 in any state → IDLE next cycle, without updating `hi_o`/`lo_o` and without asserting `result_valid_o`.
- `hi_o`/`lo_o` change only on the cycle entering DONE and hold otherwise.

## Timing
- `stall_o` = `(IDLE & start) | MUL | DIV`. It is combinational from inputs in IDLE and registered state otherwise. It is low in DONE.
- MULT/MULTU: start cycle T0, MUL at T1, DONE at T2. `stall_o` is high for 2 cycles (T0–T1).
- DIV/DIVU (b≠0): DIV occupies T1–T32, DONE at T33. `stall_o` is high for 33 cycles.
- Divide by zero: DONE at T1. `stall_o` is high for 1 cycle.
- `result_valid_o` rises in the DONE cycle. It falls the cycle after DONE exits.
- Reset values: state=IDLE, `stall_o`=0 (with `start` low), `result_valid_o`=0, `hi_o`=0, `lo_o`=0, counter=0.
- Reset asserted mid-operation returns immediately to IDLE with all outputs at reset values.
- `flush_i` and `start` in the same IDLE cycle: the flush wins, nothing starts, and `stall_o` stays 0.
- `flush_i` in DONE: → IDLE and `result_valid_o` drops next cycle. `hi_o`/`lo_o` keep their values.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5 → `stall_o` high 2 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, `result_valid_o` for 1 cycle.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIVU a=100, b=7 → exactly 33 stall cycles, then lo=14, hi=2. DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. DIVU a=0x1234, b=0 → 1 stall cycle, hi=0x1234, lo=0xFFFFFFFF.
- DIV 100/7 with `flush_i` pulsed at iteration 10 → IDLE next cycle, `stall_o`=0, no `result_valid_o`, hi/lo unchanged from prior result. Repeat with `rst` pulsed mid-divide → all outputs 0.
- MULT completing with `hold_i`=1 for 3 cycles → DONE held 4 cycles, `stall_o`=0 throughout, no restart. A back-to-back DIV issued after release starts normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit for the EX stage.
//   Multiplies take one MUL cycle. Divides take 32 restoring shift-subtract cycles.
//   Both finish in DONE, which presents {hi_o, lo_o} with result_valid_o high.
// Ports:
//   clk, rst            core clock (rising edge), asynchronous active-high reset
//   alucontrol          EX ALU control; only the four MULT/DIV codes start an operation
//   valid_e             EX stage holds a live instruction
//   flush_i             aborts any operation; hi_o/lo_o are left untouched
//   hold_i              downstream stall; keeps the unit in DONE
//   a, b                rs / rt operands
//   stall_o             stall request for F..E
//   result_valid_o      hi_o/lo_o belong to the current EX instruction
//   hi_o, lo_o          product[63:32]/[31:0], or remainder/quotient
module muldiv_unit #(
   parameter int unsigned DIV_ITER      = 32,
   parameter logic [4:0]  MULT_CONTROL  = 5'b11000,
   parameter logic [4:0]  MULTU_CONTROL = 5'b11001,
   parameter logic [4:0]  DIV_CONTROL   = 5'b11010,
   parameter logic [4:0]  DIVU_CONTROL  = 5'b11011
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  alucontrol,
   input  logic        valid_e,
   input  logic        flush_i,
   input  logic        hold_i,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        stall_o,
   output logic        result_valid_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

   localparam logic [5:0] LastIter = 6'(DIV_ITER - 1);

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d;          // multiplicand, or dividend/quotient shift register
   logic [31:0] b_q, b_d;          // multiplier, or divisor magnitude
   logic [31:0] rem_q, rem_d;
   logic        signed_q, signed_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;

   logic        is_mul, is_div, signed_op, start;
   logic [63:0] mul_a, mul_b, product;
   logic [32:0] shifted;
   logic        sub_ok;
   logic [31:0] rem_next, quo_next;

   always_comb begin
      is_mul    = (alucontrol == MULT_CONTROL) || (alucontrol == MULTU_CONTROL);
      is_div    = (alucontrol == DIV_CONTROL) || (alucontrol == DIVU_CONTROL);
      signed_op = (alucontrol == MULT_CONTROL) || (alucontrol == DIV_CONTROL);
      start     = valid_e & ~flush_i & (is_mul | is_div);
   end

   // Sign-extending to 64 bits makes the low 64 bits of an unsigned multiply the signed product.
   always_comb begin
      mul_a   = {{32{signed_q & a_q[31]}}, a_q};
      mul_b   = {{32{signed_q & b_q[31]}}, b_q};
      product = mul_a * mul_b;
   end

   // One restoring division step; the dividend MSB shifts into the partial remainder.
   always_comb begin
      shifted  = {rem_q, a_q[31]};
      sub_ok   = shifted >= {1'b0, b_q};
      rem_next = sub_ok ? 32'(shifted - {1'b0, b_q}) : shifted[31:0];
      quo_next = {a_q[30:0], sub_ok};
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      rem_d     = rem_q;
      signed_d  = signed_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               signed_d = signed_op;
               if (is_mul) begin
                  a_d     = a;
                  b_d     = b;
                  state_d = StMul;
               end else if (b == 32'd0) begin
                  hi_d    = a;
                  lo_d    = 32'hFFFF_FFFF;
                  state_d = StDone;
               end else begin
                  // Divide entry: work on magnitudes, remember the result signs.
                  a_d       = (signed_op && a[31]) ? -a : a;
                  b_d       = (signed_op && b[31]) ? -b : b;
                  neg_quo_d = signed_op & (a[31] ^ b[31]);
                  neg_rem_d = signed_op & a[31];
                  rem_d     = 32'd0;
                  cnt_d     = 6'd0;
                  state_d   = StDiv;
               end
            end
         end
         StMul: begin
            hi_d    = product[63:32];
            lo_d    = product[31:0];
            state_d = StDone;
         end
         StDiv: begin
            rem_d = rem_next;
            a_d   = quo_next;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == LastIter) begin
               hi_d    = neg_rem_q ? -rem_next : rem_next;
               lo_d    = neg_quo_q ? -quo_next : quo_next;
               state_d = StDone;
            end
         end
         StDone: begin
            // start is deliberately ignored here so the retiring instruction cannot retrigger.
            if (!hold_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (flush_i) begin
         state_d = StIdle;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= 6'd0;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         rem_q     <= 32'd0;
         signed_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         rem_q     <= rem_d;
         signed_q  <= signed_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   always_comb begin
      stall_o        = ((state_q == StIdle) & start) | (state_q == StMul) | (state_q == StDiv);
      result_valid_o = (state_q == StDone);
      hi_o           = hi_q;
      lo_o           = lo_q;
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed plus randomized checks of muldiv_unit against a plain-arithmetic model.
module tb_muldiv_unit;

   localparam logic [4:0] CMult  = 5'b11000;
   localparam logic [4:0] CMultu = 5'b11001;
   localparam logic [4:0] CDiv   = 5'b11010;
   localparam logic [4:0] CDivu  = 5'b11011;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  alucontrol;
   logic        valid_e, flush_i, hold_i;
   logic [31:0] a, b;
   logic        stall_o, result_valid_o;
   logic [31:0] hi_o, lo_o;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] last_hi, last_lo;

   muldiv_unit dut (
      .clk            (clk),
      .rst            (rst),
      .alucontrol     (alucontrol),
      .valid_e        (valid_e),
      .flush_i        (flush_i),
      .hold_i         (hold_i),
      .a              (a),
      .b              (b),
      .stall_o        (stall_o),
      .result_valid_o (result_valid_o),
      .hi_o           (hi_o),
      .lo_o           (lo_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish, expected finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: MIPS semantics from ordinary 64-bit integer arithmetic.
   task automatic model(input logic [4:0] ctrl, input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] eh, output logic [31:0] el, output int est);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      if (ctrl == CMult || ctrl == CMultu) begin
         if (ctrl == CMult) p = 64'(sa * sb);
         else               p = {32'd0, av} * {32'd0, bv};
         eh  = p[63:32];
         el  = p[31:0];
         est = 2;
      end else if (bv == 32'd0) begin
         eh  = av;
         el  = 32'hFFFF_FFFF;
         est = 1;
      end else begin
         if (ctrl == CDiv) begin
            q = sa / sb;
            r = sa % sb;
            p = 64'(q);
            el = p[31:0];
            p = 64'(r);
            eh = p[31:0];
         end else begin
            el = av / bv;
            eh = av % bv;
         end
         est = 33;
      end
   endtask

   // Issue at a falling edge and run to the first DONE cycle; valid_e stays high.
   task automatic do_op(input string tag, input logic [4:0] ctrl, input logic [31:0] av,
                        input logic [31:0] bv);
      logic [31:0] eh, el;
      int          est, stalls;
      model(ctrl, av, bv, eh, el, est);
      alucontrol = ctrl;
      valid_e    = 1'b1;
      a          = av;
      b          = bv;
      stalls     = 0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (!stall_o) break;
         stalls++;
         @(negedge clk);
      end
      check({tag, ".stalls"}, 32'(stalls), 32'(est));
      check({tag, ".valid"}, {31'd0, result_valid_o}, 32'd1);
      check({tag, ".hi"}, hi_o, eh);
      check({tag, ".lo"}, lo_o, el);
      last_hi = eh;
      last_lo = el;
   endtask

   // Retire the instruction and confirm DONE is left the next cycle.
   task automatic finish_op(input string tag);
      valid_e = 1'b0;
      hold_i  = 1'b0;
      @(negedge clk);
      #1;
      check({tag, ".valid_drop"}, {31'd0, result_valid_o}, 32'd0);
      check({tag, ".stall_idle"}, {31'd0, stall_o}, 32'd0);
   endtask

   initial begin
      logic [4:0]  ctrls [4];
      logic [4:0]  rc;
      logic [31:0] ra, rb;
      int          sel;
      ctrls[0] = CMult;
      ctrls[1] = CMultu;
      ctrls[2] = CDiv;
      ctrls[3] = CDivu;

      rst        = 1'b1;
      alucontrol = 5'd0;
      valid_e    = 1'b0;
      flush_i    = 1'b0;
      hold_i     = 1'b0;
      a          = 32'd0;
      b          = 32'd0;
      #1;
      check("reset.stall", {31'd0, stall_o}, 32'd0);
      check("reset.valid", {31'd0, result_valid_o}, 32'd0);
      check("reset.hi", hi_o, 32'd0);
      check("reset.lo", lo_o, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      do_op("mult_neg3x5", CMult, 32'hFFFF_FFFD, 32'd5);
      check("mult_neg3x5.hi_const", hi_o, 32'hFFFF_FFFF);
      check("mult_neg3x5.lo_const", lo_o, 32'hFFFF_FFF1);
      finish_op("mult_neg3x5");
      do_op("multu_max", CMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("multu_max.hi_const", hi_o, 32'hFFFF_FFFE);
      finish_op("multu_max");
      do_op("divu_100_7", CDivu, 32'd100, 32'd7);
      check("divu_100_7.lo_const", lo_o, 32'd14);
      check("divu_100_7.hi_const", hi_o, 32'd2);
      finish_op("divu_100_7");
      do_op("div_m7_2", CDiv, 32'hFFFF_FFF9, 32'd2);
      check("div_m7_2.lo_const", lo_o, 32'hFFFF_FFFD);
      finish_op("div_m7_2");
      do_op("div_ovf", CDiv, 32'h8000_0000, 32'hFFFF_FFFF);
      check("div_ovf.lo_const", lo_o, 32'h8000_0000);
      finish_op("div_ovf");
      do_op("divu_zero", CDivu, 32'h1234, 32'd0);
      finish_op("divu_zero");
      do_op("div_zero", CDiv, 32'h8765_4321, 32'd0);
      finish_op("div_zero");

      // Flush mid-divide: result registers keep the previous result.
      alucontrol = CDiv;
      valid_e    = 1'b1;
      a          = 32'd100;
      b          = 32'd7;
      for (int i = 0; i < 11; i++) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      valid_e = 1'b0;
      #1;
      check("flush_div.stall", {31'd0, stall_o}, 32'd0);
      check("flush_div.valid", {31'd0, result_valid_o}, 32'd0);
      check("flush_div.hi", hi_o, last_hi);
      check("flush_div.lo", lo_o, last_lo);
      @(negedge clk);
      #1;
      check("flush_div.valid_after", {31'd0, result_valid_o}, 32'd0);

      // Flush and start together in IDLE: nothing starts.
      @(negedge clk);
      alucontrol = CDivu;
      valid_e    = 1'b1;
      flush_i    = 1'b1;
      #1;
      check("flush_start.stall", {31'd0, stall_o}, 32'd0);
      @(negedge clk);
      flush_i = 1'b0;
      valid_e = 1'b0;
      #1;
      check("flush_start.stall_next", {31'd0, stall_o}, 32'd0);
      check("flush_start.valid", {31'd0, result_valid_o}, 32'd0);

      // Hold in DONE for 3 cycles with the MULT still presented: no restart, no stall.
      @(negedge clk);
      hold_i = 1'b1;
      do_op("mult_hold", CMult, 32'd1234, 32'hFFFF_FF00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check("mult_hold.valid", {31'd0, result_valid_o}, 32'd1);
         check("mult_hold.stall", {31'd0, stall_o}, 32'd0);
         check("mult_hold.lo", lo_o, last_lo);
      end
      finish_op("mult_hold");
      @(negedge clk);
      do_op("div_after_hold", CDiv, 32'hFFFF_FC18, 32'd9);
      finish_op("div_after_hold");

      // Flush in DONE: result_valid_o drops, values stay.
      @(negedge clk);
      hold_i = 1'b1;
      do_op("mult_flush_done", CMultu, 32'd77, 32'd3);
      flush_i = 1'b1;
      valid_e = 1'b0;
      @(negedge clk);
      flush_i = 1'b0;
      hold_i  = 1'b0;
      #1;
      check("flush_done.valid", {31'd0, result_valid_o}, 32'd0);
      check("flush_done.lo", lo_o, last_lo);

      // Reset mid-divide.
      @(negedge clk);
      alucontrol = CDivu;
      valid_e    = 1'b1;
      a          = 32'd100;
      b          = 32'd7;
      for (int i = 0; i < 6; i++) @(negedge clk);
      valid_e = 1'b0;
      rst     = 1'b1;
      #1;
      check("rst_div.stall", {31'd0, stall_o}, 32'd0);
      check("rst_div.valid", {31'd0, result_valid_o}, 32'd0);
      check("rst_div.hi", hi_o, 32'd0);
      check("rst_div.lo", lo_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int n = 0; n < 24; n++) begin
         rc  = ctrls[$urandom_range(0, 3)];
         ra  = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0)      rb = 32'd0;
         else if (sel == 1) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end else if (sel == 2) rb = 32'($urandom_range(1, 15));
         else               rb = $urandom;
         do_op($sformatf("rand%0d", n), rc, ra, rb);
         finish_op($sformatf("rand%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
